// File: rtl/llc_bus_snoop_responder_pkg.sv
// Shared LLC bus definitions for the snoop responder.
// Contents:
//   busOperation   - bus operation issued by the LLC
//   snoopResults   - snoop result returned to the LLC
//   responderState - responder FSM states
//   SNOOP_*_CODE   - address-decode constants for the result rule
//   snoop_decode() - maps a latched op and addr[1:0] to a snoop result
package llc_bus_snoop_responder_pkg;

    typedef enum logic [2:0] {
        NOBUSOP    = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } busOperation;

    typedef enum logic [1:0] {
        NORESULT = 2'd0,
        HIT      = 2'd1,
        HITM     = 2'd2,
        NOHIT    = 2'd3
    } snoopResults;

    localparam logic [1:0] SNOOP_HIT_CODE  = 2'b00;
    localparam logic [1:0] SNOOP_HITM_CODE = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_SNOOP = 2'd1,
        R_RESP  = 2'd2,
        R_DATA  = 2'd3
    } responderState;

    // WRITE never snoops; NOBUSOP never reaches a response but is mapped for completeness.
    function automatic snoopResults snoop_decode(input busOperation op, input logic [1:0] addr_lo);
        snoopResults res;
        if (op == WRITE || op == NOBUSOP) begin
            res = NORESULT;
        end else if (addr_lo == SNOOP_HIT_CODE) begin
            res = HIT;
        end else if (addr_lo == SNOOP_HITM_CODE) begin
            res = HITM;
        end else begin
            res = NOHIT;
        end
        return res;
    endfunction

endpackage

// File: rtl/llc_bus_snoop_responder_counter.sv
// Saturating statistics counter used for the per-result snoop tallies.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset, clears the count
//   i_inc   - increment enable (one count per cycle asserted)
//   o_count - current count; sticks at all-ones instead of wrapping
module snoop_stat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/llc_bus_snoop_responder.sv
// Far end of the LLC shared bus: answers one bus operation at a time with a
// snoop result after a fixed latency, then streams a line fill for READ/RWIM.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   i_req_valid/o_req_ready          - request handshake
//   i_req_op, i_req_addr             - bus operation and physical address
//   o_rsp_valid/i_rsp_ready          - snoop result handshake
//   o_rsp_result                     - snoop result (NORESULT outside a response)
//   o_dat_valid/i_dat_ready          - line-fill beat handshake
//   o_dat_beat, o_dat_last           - beat index (0 first) and final-beat flag
//   o_dat_src                        - 1 when a peer cache supplies the line (HITM)
//   o_err_op                         - one-cycle pulse after a NOBUSOP is accepted
//   o_cnt_hit/o_cnt_hitm/o_cnt_nohit - saturating counts of results returned
module llc_bus_snoop_responder
    import llc_bus_snoop_responder_pkg::*;
#(
    parameter int unsigned SNOOP_LATENCY = 2,
    parameter int unsigned DATA_BEATS    = 4,
    parameter int unsigned CNT_W         = 32,
    localparam int unsigned BEAT_W       = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  busOperation       i_req_op,
    input  logic [31:0]       i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output snoopResults       o_rsp_result,
    output logic              o_dat_valid,
    input  logic              i_dat_ready,
    output logic [BEAT_W-1:0] o_dat_beat,
    output logic              o_dat_src,
    output logic              o_dat_last,
    output logic              o_err_op,
    output logic [CNT_W-1:0]  o_cnt_hit,
    output logic [CNT_W-1:0]  o_cnt_hitm,
    output logic [CNT_W-1:0]  o_cnt_nohit
);

    localparam int unsigned LAT_W = (SNOOP_LATENCY > 1) ? $clog2(SNOOP_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(SNOOP_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(DATA_BEATS - 1);

    responderState     r_state, w_state_d;
    busOperation       r_op, w_op_d;
    logic [1:0]        r_addr_lo, w_addr_lo_d;  // only addr[1:0] feeds the result rule
    logic [LAT_W-1:0]  r_lat, w_lat_d;
    logic [BEAT_W-1:0] r_beat, w_beat_d;
    logic              r_err, w_err_d;

    logic              w_unused_addr;
    snoopResults       w_result;
    logic              w_in_resp;
    logic              w_in_data;
    logic              w_is_last;
    logic              w_rsp_hs;

    assign w_unused_addr = ^i_req_addr[31:2];

    assign w_result  = snoop_decode(r_op, r_addr_lo);
    assign w_in_resp = (r_state == R_RESP);
    assign w_in_data = (r_state == R_DATA);
    assign w_is_last = (r_beat == BEAT_LAST);
    assign w_rsp_hs  = w_in_resp && i_rsp_ready;

    always_comb begin
        w_state_d   = r_state;
        w_op_d      = r_op;
        w_addr_lo_d = r_addr_lo;
        w_lat_d     = r_lat;
        w_beat_d    = r_beat;
        w_err_d     = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_op == NOBUSOP) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_op_d      = i_req_op;
                        w_addr_lo_d = i_req_addr[1:0];
                        w_lat_d     = LAT_LOAD;
                        w_state_d   = R_SNOOP;
                    end
                end
            end
            R_SNOOP: begin
                // Loaded with LATENCY-1 and exits on zero, so RESP appears
                // exactly SNOOP_LATENCY edges after the accepting edge.
                if (r_lat == '0) begin
                    w_state_d = R_RESP;
                end else begin
                    w_lat_d = r_lat - LAT_W'(1);
                end
            end
            R_RESP: begin
                if (i_rsp_ready) begin
                    if (r_op == READ || r_op == RWIM) begin
                        w_beat_d  = '0;
                        w_state_d = R_DATA;
                    end else begin
                        w_state_d = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (i_dat_ready) begin
                    if (w_is_last) begin
                        w_beat_d  = '0;
                        w_state_d = R_IDLE;
                    end else begin
                        w_beat_d = r_beat + BEAT_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_op      <= NOBUSOP;
            r_addr_lo <= 2'b00;
            r_lat     <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_op      <= w_op_d;
            r_addr_lo <= w_addr_lo_d;
            r_lat     <= w_lat_d;
            r_beat    <= w_beat_d;
            r_err     <= w_err_d;
        end
    end

    assign o_req_ready  = (r_state == R_IDLE);
    assign o_rsp_valid  = w_in_resp;
    assign o_rsp_result = w_in_resp ? w_result : NORESULT;
    assign o_dat_valid  = w_in_data;
    assign o_dat_beat   = r_beat;
    assign o_dat_last   = w_in_data && w_is_last;
    assign o_dat_src    = w_in_data && (w_result == HITM);
    assign o_err_op     = r_err;

    snoop_stat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_hit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rsp_hs && (w_result == HIT)),
        .o_count (o_cnt_hit)
    );

    snoop_stat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_hitm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rsp_hs && (w_result == HITM)),
        .o_count (o_cnt_hitm)
    );

    snoop_stat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_nohit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rsp_hs && (w_result == NOHIT)),
        .o_count (o_cnt_nohit)
    );

endmodule
